// File: rtl/rsa_byte_ctrl_pkg.sv
// Shared constants and state encoding for the RSA byte-stream front end.
package rsa_byte_ctrl_pkg;

    localparam int unsigned BYTE_W   = 8;
    localparam int unsigned OP_WIDTH = 256;
    localparam int unsigned NBYTES   = OP_WIDTH / BYTE_W;

    localparam logic [2:0] ST_LOAD_N = 3'd0;
    localparam logic [2:0] ST_LOAD_E = 3'd1;
    localparam logic [2:0] ST_LOAD_M = 3'd2;
    localparam logic [2:0] ST_START  = 3'd3;
    localparam logic [2:0] ST_HOLD   = 3'd4;
    localparam logic [2:0] ST_WAIT   = 3'd5;
    localparam logic [2:0] ST_SEND   = 3'd6;

    function automatic logic is_load_state(input logic [2:0] s);
        return (s == ST_LOAD_N) || (s == ST_LOAD_E) || (s == ST_LOAD_M);
    endfunction

endpackage

// File: rtl/rsa_byte_shreg.sv
// WIDTH-bit register that shifts a byte in at the LSB end, with an optional
// parallel load (parallel load wins when both are requested).
module rsa_byte_shreg
    import rsa_byte_ctrl_pkg::*;
#(
    parameter int WIDTH = OP_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             shift_en,
    input  logic [7:0]       byte_in,
    input  logic             load_en,
    input  logic [WIDTH-1:0] load_data,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (load_en) begin
            q <= load_data;
        end else if (shift_en) begin
            q <= {q[WIDTH-BYTE_W-1:0], byte_in};
        end
    end

endmodule

// File: rtl/rsa_byte_ctrl.sv
// Byte-stream front end for the modular-exponentiation core: loads N, e, M
// big-endian, starts the core, streams S back. KEY_REUSE_EN keeps N/e loaded.
module rsa_byte_ctrl
    import rsa_byte_ctrl_pkg::*;
#(
    parameter int WIDTH = OP_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [7:0]       out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             core_start,
    input  logic             core_ready,
    output logic [WIDTH-1:0] core_N,
    output logic [WIDTH-1:0] core_e,
    output logic [WIDTH-1:0] core_M,
    input  logic [WIDTH-1:0] core_S,
    output logic             busy,
    output logic [2:0]       state_dbg
);

    localparam int NB    = WIDTH / BYTE_W;
    localparam int CNT_W = (NB > 1) ? $clog2(NB) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NB - 1);

`ifdef KEY_REUSE_EN
    localparam logic [2:0] ST_AFTER_SEND = ST_LOAD_M;
`else
    localparam logic [2:0] ST_AFTER_SEND = ST_LOAD_N;
`endif

    logic [2:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] s_q;
    logic             in_fire;
    logic             out_fire;
    logic             cnt_last;

    // Both byte ports: a byte moves on a clock edge where valid && ready;
    // the sender holds data stable until then, the receiver may stall freely.
    assign in_ready  = is_load_state(state);
    assign in_fire   = in_valid && in_ready;
    assign out_valid = (state == ST_SEND);
    assign out_fire  = out_valid && out_ready;
    assign out_data  = s_q[WIDTH-1 -: BYTE_W];
    assign cnt_last  = (cnt == CNT_LAST);
    assign state_dbg = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_LOAD_N;
            cnt        <= '0;
            core_start <= 1'b0;
            busy       <= 1'b0;
        end else begin
            case (state)
                ST_LOAD_N, ST_LOAD_E, ST_LOAD_M: begin
                    if (in_fire) begin
                        if (cnt_last) begin
                            cnt <= '0;
                            if (state == ST_LOAD_N) begin
                                state <= ST_LOAD_E;
                            end else if (state == ST_LOAD_E) begin
                                state <= ST_LOAD_M;
                            end else begin
                                // Registered start so it is high exactly during START.
                                state      <= ST_START;
                                core_start <= 1'b1;
                                busy       <= 1'b1;
                            end
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                ST_START: begin
                    core_start <= 1'b0;
                    state      <= ST_HOLD;
                end
                // The core's ready is registered and still reads 1 here.
                ST_HOLD: state <= ST_WAIT;
                ST_WAIT: begin
                    if (core_ready) begin
                        state <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (out_fire) begin
                        if (cnt_last) begin
                            cnt   <= '0;
                            busy  <= 1'b0;
                            state <= ST_AFTER_SEND;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    state      <= ST_LOAD_N;
                    cnt        <= '0;
                    core_start <= 1'b0;
                    busy       <= 1'b0;
                end
            endcase
        end
    end

    rsa_byte_shreg #(.WIDTH(WIDTH)) u_n_reg (
        .clk       (clk),
        .rst       (rst),
        .shift_en  (in_fire && (state == ST_LOAD_N)),
        .byte_in   (in_data),
        .load_en   (1'b0),
        .load_data ('0),
        .q         (core_N)
    );

    rsa_byte_shreg #(.WIDTH(WIDTH)) u_e_reg (
        .clk       (clk),
        .rst       (rst),
        .shift_en  (in_fire && (state == ST_LOAD_E)),
        .byte_in   (in_data),
        .load_en   (1'b0),
        .load_data ('0),
        .q         (core_e)
    );

    rsa_byte_shreg #(.WIDTH(WIDTH)) u_m_reg (
        .clk       (clk),
        .rst       (rst),
        .shift_en  (in_fire && (state == ST_LOAD_M)),
        .byte_in   (in_data),
        .load_en   (1'b0),
        .load_data ('0),
        .q         (core_M)
    );

    // Result register: captured once from the core, then drained MSB byte first.
    rsa_byte_shreg #(.WIDTH(WIDTH)) u_s_reg (
        .clk       (clk),
        .rst       (rst),
        .shift_en  (out_fire),
        .byte_in   (8'h00),
        .load_en   ((state == ST_WAIT) && core_ready),
        .load_data (core_S),
        .q         (s_q)
    );

endmodule

// File: tb/tb_rsa_byte_ctrl.sv
// Bench for rsa_byte_ctrl: behavioural ME core model, byte driver tasks and an
// output monitor that pops expected result bytes from a scoreboard queue.
module tb_rsa_byte_ctrl;

    logic         clk = 1'b0;
    logic         rst;
    logic [7:0]   in_data;
    logic         in_valid;
    logic         in_ready;
    logic [7:0]   out_data;
    logic         out_valid;
    logic         out_ready;
    logic         core_start;
    logic         core_ready;
    logic [255:0] core_N;
    logic [255:0] core_e;
    logic [255:0] core_M;
    logic [255:0] core_S;
    logic         busy;
    logic [2:0]   state_dbg;

    always #5 clk = ~clk;

    rsa_byte_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .core_start (core_start),
        .core_ready (core_ready),
        .core_N     (core_N),
        .core_e     (core_e),
        .core_M     (core_M),
        .core_S     (core_S),
        .busy       (busy),
        .state_dbg  (state_dbg)
    );

    int           checks = 0;
    int           errors = 0;
    int           bytes_acc = 0;
    logic [7:0]   exp_q[$];
    bit           rand_ready = 1'b0;
    int           gap_max = 0;
    bit           core_pattern = 1'b0;
    int           core_lat = 3;
    logic [255:0] pattern;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, act, exp);
        end
    endtask

    // Behavioural core: ready is registered, drops one cycle after the start
    // cycle, result appears core_lat cycles later. S is garbage while computing.
    function automatic logic [255:0] modexp(input logic [31:0] n, input logic [31:0] e,
                                            input logic [31:0] m);
        longint unsigned r, b;
        if (n == 0) return '0;
        r = 1 % longint'(n);
        b = longint'(m) % longint'(n);
        for (int i = 0; i < 32; i++) begin
            if (e[i]) r = (r * b) % longint'(n);
            b = (b * b) % longint'(n);
        end
        return {224'b0, r[31:0]};
    endfunction

    logic arm;
    logic running;
    int   lat_cnt;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            core_ready <= 1'b1;
            core_S     <= '0;
            arm        <= 1'b0;
            running    <= 1'b0;
            lat_cnt    <= 0;
        end else if (core_start) begin
            core_S <= {8{32'hDEADBEEF}};
            arm    <= 1'b1;
        end else if (arm) begin
            arm        <= 1'b0;
            core_ready <= 1'b0;
            running    <= 1'b1;
            lat_cnt    <= core_lat;
        end else if (running) begin
            if (lat_cnt == 0) begin
                running    <= 1'b0;
                core_ready <= 1'b1;
                core_S     <= core_pattern ? pattern
                                           : modexp(core_N[31:0], core_e[31:0], core_M[31:0]);
            end else begin
                lat_cnt <= lat_cnt - 1;
            end
        end
    end

    // Output monitor: decides out_ready each cycle and scores accepted bytes.
    logic [7:0] prev_data = 8'h00;
    bit         prev_stall = 1'b0;

    initial begin
        logic [7:0] e8;
        out_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall && out_valid)
                    check("out_data_stable", 256'(out_data), 256'(prev_data));
                out_ready = rand_ready ? ($urandom_range(0, 1) == 1) : 1'b1;
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_out got %0h expected none", out_data);
                    end else begin
                        e8 = exp_q.pop_front();
                        check("out_byte", 256'(out_data), 256'(e8));
                    end
                end
                prev_stall = out_valid && !out_ready;
                prev_data  = out_data;
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int gap;
        gap = (gap_max > 0) ? $urandom_range(0, gap_max) : 0;
        repeat (gap) @(negedge clk);
        in_data  = b;
        in_valid = 1'b1;
        for (int t = 0; t < 1000; t++) begin
            if (in_ready) begin
                @(posedge clk);
                @(negedge clk);
                in_valid = 1'b0;
                bytes_acc++;
                return;
            end
            @(negedge clk);
        end
        checks++;
        errors++;
        $display("FAIL in_ready_timeout got 0 expected 1");
        in_valid = 1'b0;
    endtask

    task automatic send_operand(input logic [7:0] v);
        repeat (31) send_byte(8'h00);
        send_byte(v);
    endtask

    task automatic push_result(input logic [7:0] v);
        repeat (31) exp_q.push_back(8'h00);
        exp_q.push_back(v);
    endtask

    task automatic wait_drain();
        for (int t = 0; t < 5000; t++) begin
            @(negedge clk);
            if (exp_q.size() == 0) break;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout got %0d bytes left expected 0", exp_q.size());
            exp_q.delete();
        end
        @(negedge clk);
        check("busy_after_send", 256'(busy), 256'(0));
        check("out_valid_after_send", 256'(out_valid), 256'(0));
    endtask

    // Loads operands (all three, or only M), checks the start handshake, drains.
    task automatic run_op(input bit full, input logic [7:0] n, input logic [7:0] e,
                          input logic [7:0] m);
        bytes_acc = 0;
        if (full) begin
            send_operand(n);
            send_operand(e);
        end
        send_operand(m);
        check("bytes_accepted", 256'(bytes_acc), full ? 256'(96) : 256'(32));
        check("in_ready_after_load", 256'(in_ready), 256'(0));
        check("core_start_high", 256'(core_start), 256'(1));
        check("busy_at_start", 256'(busy), 256'(1));
        @(negedge clk);
        check("core_start_one_cycle", 256'(core_start), 256'(0));
        wait_drain();
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        for (int i = 0; i < 32; i++) pattern[255 - 8*i -: 8] = 8'(i + 1);
        @(negedge clk);
        check("rst_in_ready", 256'(in_ready), 256'(1));
        check("rst_out_valid", 256'(out_valid), 256'(0));
        check("rst_out_data", 256'(out_data), 256'(0));
        check("rst_core_start", 256'(core_start), 256'(0));
        check("rst_busy", 256'(busy), 256'(0));
        check("rst_state", 256'(state_dbg), 256'(0));
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // 2^7 mod 143 = 128
        push_result(8'h80);
        run_op(1'b1, 8'h8F, 8'h07, 8'h02);

`ifdef KEY_REUSE_EN
        // Key retained: 3^7 mod 143 = 2187 - 15*143 = 42
        push_result(8'h2A);
        run_op(1'b0, 8'h00, 8'h00, 8'h03);
`endif

        // 5^3 mod 33 = 125 - 99 = 26
        do_reset();
        push_result(8'h1A);
        run_op(1'b1, 8'h21, 8'h03, 8'h05);

        // Slow core returning a fixed pattern; input must be refused while busy.
        do_reset();
        core_pattern = 1'b1;
        core_lat     = 10;
        for (int i = 1; i <= 32; i++) exp_q.push_back(8'(i));
        bytes_acc = 0;
        send_operand(8'h8F);
        send_operand(8'h07);
        send_operand(8'h02);
        check("p_core_start_high", 256'(core_start), 256'(1));
        in_data  = 8'hAA;
        in_valid = 1'b1;
        @(negedge clk);
        check("p_core_start_one_cycle", 256'(core_start), 256'(0));
        repeat (3) @(negedge clk);
        check("p_in_ready_busy", 256'(in_ready), 256'(0));
        check("p_busy_wait", 256'(busy), 256'(1));
        in_valid = 1'b0;
        wait_drain();
        core_pattern = 1'b0;
        core_lat     = 3;

        // Backpressure on both ports.
        do_reset();
        gap_max    = 3;
        rand_ready = 1'b1;
        push_result(8'h80);
        run_op(1'b1, 8'h8F, 8'h07, 8'h02);
        gap_max    = 0;
        rand_ready = 1'b0;

        // Reset in the middle of loading e.
        do_reset();
        bytes_acc = 0;
        for (int i = 0; i < 40; i++) send_byte(8'($urandom_range(1, 255)));
        rst = 1'b1;
        #1;
        check("mid_rst_in_ready", 256'(in_ready), 256'(1));
        check("mid_rst_out_valid", 256'(out_valid), 256'(0));
        check("mid_rst_core_start", 256'(core_start), 256'(0));
        check("mid_rst_busy", 256'(busy), 256'(0));
        check("mid_rst_state", 256'(state_dbg), 256'(0));
        check("mid_rst_core_N", core_N, 256'(0));
        check("mid_rst_core_e", core_e, 256'(0));
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        push_result(8'h80);
        run_op(1'b1, 8'h8F, 8'h07, 8'h02);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
